cache_control: RTL and testbench
================================

# cache_control

Control FSM for the direct-mapped, 8-set, write-back L1 cache built from the team's 8-entry `array` instances (data, tag, valid, dirty). It sits between the pipeline's memory port and the physical-memory port. It takes the datapath's tag-compare and dirty status and sequences the array load enables, the fill/merge mux selects and the physical-memory handshake. It holds no line data itself.

## Interface
- `CNT_WIDTH`, 16, width of each statistics counter (used only with `CACHE_STATS_EN`).

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  CPU read request; held until `mem_resp`.
- `mem_write`  in  1  CPU write request; held until `mem_resp`.
- `hit`  in  1  datapath: valid[index] && tag[index]==addr tag (combinational).
- `dirty`  in  1  datapath: dirty[index] (combinational).
- `pmem_resp`  in  1  physical memory: line transfer complete (1-cycle pulse).
- `mem_resp`  out  1  CPU request complete.
- `pmem_read`  out  1  line fill request.
- `pmem_write`  out  1  line writeback request.
- `pmem_addr_sel`  out  1  0 = {CPU tag, index}; 1 = {stored tag, index}.
- `data_in_sel`  out  1  data array input: 0 = CPU write-merge, 1 = pmem line.
- `load_data`, `load_tag`, `load_valid`, `load_dirty`  out  1 each  array load enables.
- `dirty_in`  out  1  value written to the dirty array.
- `hit_count`, `miss_count`, `wb_count`  out  `CNT_WIDTH` each  statistics (only with `CACHE_STATS_EN`).

## Operation
- States: IDLE, WRITEBACK, ALLOCATE. Outputs are Mealy-decoded from the state and inputs. All outputs are 0 unless stated.
- A request is `mem_read | mem_write`. If both are asserted, it is treated as a write.
- IDLE, no request: stay.
- IDLE, request, `hit`:
  - Assert `mem_resp`.
  - For a write, also assert `load_data` (`data_in_sel`=0), `load_dirty`, `dirty_in`=1.
  - Stay in IDLE.
- IDLE, request, miss:
  - `dirty`=1: go to WRITEBACK.
  - `dirty`=0: go to ALLOCATE.
- WRITEBACK:
  - Assert `pmem_write` and `pmem_addr_sel`=1.
  - On `pmem_resp`, go to ALLOCATE.
- ALLOCATE:
  - Assert `pmem_read` and `pmem_addr_sel`=0.
  - On `pmem_resp`, in the same cycle assert `load_data` (`data_in_sel`=1), `load_tag`, `load_valid`, `load_dirty` with `dirty_in`=0, then go to IDLE.
  - The re-check in IDLE then hits and completes the request (a write merges at that point).
- `pmem_resp` is ignored in IDLE.
- Requests drop while in WRITEBACK/ALLOCATE are illegal. The FSM completes the line transfer regardless.
- Internal `miss_pending` flag:
  - Set on leaving IDLE on a miss.
  - Cleared on `mem_resp`.
  - Reset value 0.

## Timing
- Reset: state IDLE, `miss_pending`=0, counters 0. All outputs are 0 while `rst_n`=0.
- Reset asserted mid-transaction abandons the transfer immediately. `pmem_read`/`pmem_write` drop asynchronously.
- Hit latency: `mem_resp` in the request's first cycle.
- Clean-miss latency: F + 1 cycles, where F = cycles from `pmem_read` to `pmem_resp`, inclusive.
- Dirty-miss latency: W + F + 1 cycles.
- `pmem_read`/`pmem_write` are level signals, held continuously until `pmem_resp`. They are never asserted together.
- Array loads take effect at the edge on which they are asserted. Datapath `hit` reflects them the next cycle.

## Configuration
- `CACHE_STATS_EN` defined: counters present. Each saturates at all-ones.
  - `hit_count` +1 on `mem_resp` with `miss_pending`=0.
  - `miss_count` +1 on each IDLE→WRITEBACK/ALLOCATE transition.
  - `wb_count` +1 on WRITEBACK→ALLOCATE.
- `CACHE_STATS_EN` undefined: counter ports and logic absent. FSM behaviour is identical.

## Test plan
- Reset then read with `hit`=1 → `mem_resp`=1 in the same cycle, no pmem activity; stats hit=1, miss=0.
- Write with `hit`=1 → `load_data`=1, `data_in_sel`=0, `load_dirty`=1, `dirty_in`=1, `mem_resp`=1, single cycle.
- Read miss, `dirty`=0, `pmem_resp` 3 cycles after `pmem_read` → fill loads with `dirty_in`=0 on the `pmem_resp` edge, `mem_resp` next cycle; total 4 cycles; stats hit=0, miss=1.
- Write miss, `dirty`=1 → `pmem_write` with `pmem_addr_sel`=1 until `pmem_resp`, then `pmem_read` with `pmem_addr_sel`=0, then merge write; `wb_count`=1.
- `rst_n` pulsed low during ALLOCATE → `pmem_read` drops immediately, state IDLE, counters 0; a stray `pmem_resp` afterwards causes no array load.
- `CNT_WIDTH`=2, 5 hits → `hit_count` saturates at 3.

Source files
------------

// File: rtl/cache_control.sv
// cache_control: IDLE/WRITEBACK/ALLOCATE sequencer for the direct-mapped,
// 8-set, write-back L1 cache. Holds no line data; drives array load enables,
// fill/merge selects and the physical-memory handshake.
// Optional statistics counters: define CACHE_STATS_EN.
module cache_control #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_read,
   input  logic mem_write,
   input  logic hit,
   input  logic dirty,
   input  logic pmem_resp,
   output logic mem_resp,
   output logic pmem_read,
   output logic pmem_write,
   output logic pmem_addr_sel,
   output logic data_in_sel,
   output logic load_data,
   output logic load_tag,
   output logic load_valid,
   output logic load_dirty,
   output logic dirty_in
`ifdef CACHE_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
`endif
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_miss_pending;

   logic w_req;
   logic w_mem_resp, w_pmem_read, w_pmem_write, w_pmem_addr_sel;
   logic w_data_in_sel, w_load_data, w_load_tag, w_load_valid;
   logic w_load_dirty, w_dirty_in;

   // Simultaneous read and write is handled as a write.
   assign w_req = mem_read | mem_write;

   // State register; reset abandons any line transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state and Mealy output decode.
   always_comb begin
      w_next          = r_state;
      w_mem_resp      = 1'b0;
      w_pmem_read     = 1'b0;
      w_pmem_write    = 1'b0;
      w_pmem_addr_sel = 1'b0;
      w_data_in_sel   = 1'b0;
      w_load_data     = 1'b0;
      w_load_tag      = 1'b0;
      w_load_valid    = 1'b0;
      w_load_dirty    = 1'b0;
      w_dirty_in      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_req) begin
               if (hit) begin
                  w_mem_resp = 1'b1;
                  if (mem_write) begin
                     w_load_data  = 1'b1;
                     w_load_dirty = 1'b1;
                     w_dirty_in   = 1'b1;
                  end
               end else begin
                  w_next = dirty ? WRITEBACK : ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            w_pmem_write    = 1'b1;
            w_pmem_addr_sel = 1'b1;
            if (pmem_resp) w_next = ALLOCATE;
         end
         ALLOCATE: begin
            w_pmem_read = 1'b1;
            if (pmem_resp) begin
               w_load_data   = 1'b1;
               w_data_in_sel = 1'b1;
               w_load_tag    = 1'b1;
               w_load_valid  = 1'b1;
               w_load_dirty  = 1'b1;
               w_next        = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Mealy outputs would otherwise follow hit/request while held in reset.
   assign mem_resp      = w_mem_resp      & rst_n;
   assign pmem_read     = w_pmem_read     & rst_n;
   assign pmem_write    = w_pmem_write    & rst_n;
   assign pmem_addr_sel = w_pmem_addr_sel & rst_n;
   assign data_in_sel   = w_data_in_sel   & rst_n;
   assign load_data     = w_load_data     & rst_n;
   assign load_tag      = w_load_tag      & rst_n;
   assign load_valid    = w_load_valid    & rst_n;
   assign load_dirty    = w_load_dirty    & rst_n;
   assign dirty_in      = w_dirty_in      & rst_n;

   // Remember that the current request missed so its final response is not a hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                r_miss_pending <= 1'b0;
      else if (w_mem_resp)                       r_miss_pending <= 1'b0;
      else if (r_state == IDLE && w_next != IDLE) r_miss_pending <= 1'b1;
   end

`ifdef CACHE_STATS_EN
   logic [CNT_WIDTH-1:0] r_hit_count, r_miss_count, r_wb_count;

   // Saturating hit/miss/writeback statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
         r_wb_count   <= '0;
      end else begin
         if (w_mem_resp && !r_miss_pending && r_hit_count != '1)
            r_hit_count <= r_hit_count + 1'b1;
         if (r_state == IDLE && w_next != IDLE && r_miss_count != '1)
            r_miss_count <= r_miss_count + 1'b1;
         if (r_state == WRITEBACK && w_next == ALLOCATE && r_wb_count != '1)
            r_wb_count <= r_wb_count + 1'b1;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
   assign wb_count   = r_wb_count;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: a transaction-level generator produces the
// expected per-cycle output vector for each request shape; a negedge process
// compares the DUT against it. Statistics are checked when CACHE_STATS_EN is set.
module tb_cache_control;

   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic mem_read, mem_write, hit, dirty, pmem_resp;
   logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel;
   logic load_data, load_tag, load_valid, load_dirty, dirty_in;
`ifdef CACHE_STATS_EN
   logic [CW-1:0] hit_count, miss_count, wb_count;
`endif

   cache_control #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_write(mem_write), .hit(hit), .dirty(dirty),
      .pmem_resp(pmem_resp),
      .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_addr_sel(pmem_addr_sel), .data_in_sel(data_in_sel),
      .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
      .load_dirty(load_dirty), .dirty_in(dirty_in)
`ifdef CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   logic [9:0] exp_q[$];
   int lat = 0;
   int last_lat = 0;
   int m_hit = 0, m_miss = 0, m_wb = 0;

   // vector order: mem_resp pmem_read pmem_write addr_sel data_in_sel
   //               load_data load_tag load_valid load_dirty dirty_in
   wire [9:0] w_act = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel,
                       load_data, load_tag, load_valid, load_dirty, dirty_in};

   localparam logic [9:0] V_ZERO  = 10'b0000000000;
   localparam logic [9:0] V_RDHIT = 10'b1000000000;
   localparam logic [9:0] V_WRHIT = 10'b1000010011;
   localparam logic [9:0] V_WB    = 10'b0011000000;
   localparam logic [9:0] V_RD    = 10'b0100000000;
   localparam logic [9:0] V_FILL  = 10'b0100111110;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int x);
      return (x > (1 << CW) - 1) ? (1 << CW) - 1 : x;
   endfunction

   // Compare DUT outputs with the expected vector for this cycle; also measure
   // cycles from first pmem request to mem_resp.
   always @(negedge clk) begin
      if (exp_q.size() > 0) chk("outputs", int'(w_act), int'(exp_q.pop_front()));
      if (pmem_read || pmem_write) lat++;
      else if (mem_resp) begin
         if (lat > 0) last_lat = lat + 1;
         lat = 0;
      end
   end

   task automatic step(input bit rd, input bit wr, input bit h, input bit d,
                       input bit pr, input logic [9:0] e);
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; hit = h; dirty = d; pmem_resp = pr;
      exp_q.push_back(e);
   endtask

   // kind: 0 hit, 1 clean miss, 2 dirty miss; W/F are writeback/fill cycle counts
   task automatic txn(input bit rd, input bit wr, input int kind, input int W, input int F);
      logic [9:0] fin;
      fin = wr ? V_WRHIT : V_RDHIT;
      if (kind != 0) begin
         step(rd, wr, 1'b0, kind == 2, 1'b0, V_ZERO);
         if (kind == 2)
            for (int i = 0; i < W; i++) step(rd, wr, 1'b0, 1'b1, i == W - 1, V_WB);
         for (int i = 0; i < F; i++)
            step(rd, wr, 1'b0, kind == 2, i == F - 1, (i == F - 1) ? V_FILL : V_RD);
      end
      step(rd, wr, 1'b1, 1'b0, 1'b0, fin);
      if (kind == 0) m_hit++;
      else begin
         m_miss++;
         if (kind == 2) m_wb++;
      end
      // idle separator with a stray pmem_resp, which must be ignored
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, V_ZERO);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ZERO);
      @(negedge clk); #1;
   endtask

   task automatic chk_stats;
`ifdef CACHE_STATS_EN
      chk("hit_count",  int'(hit_count),  sat(m_hit));
      chk("miss_count", int'(miss_count), sat(m_miss));
      chk("wb_count",   int'(wb_count),   sat(m_wb));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      mem_read = 1'b1; mem_write = 1'b0; hit = 1'b1; dirty = 1'b0; pmem_resp = 1'b1;
      #3;
      chk("reset_outputs", int'(w_act), 0);
      #10;
      chk("reset_outputs_held", int'(w_act), 0);
      mem_read = 1'b0; hit = 1'b0; pmem_resp = 1'b0;
      #9 rst_n = 1'b1;
      chk_stats();

      txn(1'b1, 1'b0, 0, 0, 0);          // read hit
      chk_stats();
      txn(1'b0, 1'b1, 0, 0, 0);          // write hit
      txn(1'b1, 1'b0, 1, 0, 3);          // clean read miss, F=3
      chk("clean_miss_latency", last_lat, 4);
      chk_stats();
      txn(1'b0, 1'b1, 2, 2, 3);          // dirty write miss, W=2 F=3
      chk("dirty_miss_latency", last_lat, 6);
      chk_stats();
      txn(1'b1, 1'b1, 0, 0, 0);          // read+write together acts as a write
      txn(1'b0, 1'b1, 1, 0, 1);          // clean write miss, F=1
      chk("short_fill_latency", last_lat, 2);
      chk_stats();

      // reset pulsed during ALLOCATE
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_ZERO);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RD);
      @(negedge clk); #2;
      hit = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("reset_drops_pmem_read", int'(pmem_read), 0);
      chk("reset_mid_outputs", int'(w_act), 0);
      @(posedge clk); #1;
      chk("reset_low_outputs", int'(w_act), 0);
      rst_n = 1'b1;
      lat = 0;
      m_hit = 0; m_miss = 0; m_wb = 0;
      mem_read = 1'b0; hit = 1'b0; pmem_resp = 1'b1;
      exp_q.push_back(V_ZERO);           // stray pmem_resp in IDLE: no loads
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ZERO);
      @(negedge clk); #1;
      chk_stats();

      for (int i = 0; i < 5; i++) txn(1'b1, 1'b0, 0, 0, 0);
      chk_stats();
`ifdef CACHE_STATS_EN
      chk("hit_saturation", int'(hit_count), 3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
